dmux_stream_1byn: RTL
=====================

# dmux_stream_1byn

Registered, parametrised 1-to-N stream demultiplexer: one WIDTH-bit input stream is steered to one of N output channels with valid/ready flow control on every side. It is the clocked, back-pressure-aware successor to the team's combinational 1:4 demultiplexers. It sits between a single producer and N independent consumers. An optional round-robin mode distributes words across channels without an external select.

## Interface
- WIDTH, 8, data width per word (≥1)
- N, 4, number of output channels (2..16, need not be a power of two)
- SW, $clog2(N), select width; derived, not overridden
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- in_data  input  WIDTH  input word
- in_sel  input  SW  destination channel, sampled with in_data; ignored in round-robin mode
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts word this cycle
- out_data  output  N*WIDTH  lane k = bits [k*WIDTH +: WIDTH]; only the addressed lane carries data, all others 0
- out_valid  output  N  one-hot or zero; bit k = lane k holds a word
- out_ready  input  N  consumer k accepts
- sel_err  output  1  one-cycle pulse: accepted word had in_sel ≥ N
- rr_mode  input  1  1 = round-robin steering (present only with DMUX_RR_EN)

## Operation
- One holding register (data, channel index) with states EMPTY and FULL.
- Input transfer: in_valid && in_ready. Output transfer: out_valid[k] && out_ready[k].
- in_ready = (state == EMPTY) || out_ready[held_ch]; combinational from out_ready, no combinational path from in_valid.
- EMPTY, input transfer → FULL, load word and channel.
- FULL, output transfer and no input transfer → EMPTY.
- FULL, output and input transfer in same cycle → stay FULL, load new word (full throughput).
- FULL, no output transfer → hold word and channel stable; in_ready = 0.
- in_sel ≥ N (only when N not a power of two): word accepted, discarded, state unchanged by it, sel_err = 1 the following cycle. Never enters FULL.
- out_valid = one-hot of held_ch when FULL, else all 0. out_data lane held_ch = held word, other lanes 0; all lanes 0 when EMPTY.
- Round-robin mode: channel = internal pointer ptr; ptr advances by 1 on every input transfer, wraps N-1 → 0; in_sel and sel_err unused (sel_err stays 0).

## Timing
- Latency: word accepted at edge t is visible on out_valid/out_data after edge t; consumer may take it in cycle t+1.
- Sustained throughput 1 word/cycle when the addressed consumer holds out_ready high.
- Reset values: state EMPTY, out_valid = 0, out_data = 0, sel_err = 0, ptr = 0, in_ready = 1 in first cycle after reset.
- rst asserted mid-transfer: held word dropped, outputs return to reset values at that edge; rst dominates any simultaneous transfer.
- rr_mode changes take effect on the next input transfer; ptr is not reset by toggling rr_mode.

## Configuration
- DMUX_RR_EN defined: rr_mode port and ptr register exist; round-robin steering as above.
- Not defined: no rr_mode port, no ptr; steering always from in_sel.

## Structure
- Package dmux_pkg: state enum (ST_EMPTY, ST_FULL), select-width helper function, lane-slice constant helpers.
- One sub-module natural: dmux_rr_ptr (modulo-N wrapping pointer with advance enable, synchronous reset); instantiated only under DMUX_RR_EN.
- Data path: holding register plus decoder driving out_valid and zeroed lanes.

## Test plan
- Reset: assert rst 3 cycles with in_valid=1 → out_valid=0, out_data=0, sel_err=0; in_ready=1 one cycle after release.
- Single word: in_data=8'hA5, in_sel=2, out_ready=0 → next cycle out_valid=4'b0100, lane 2 = A5, others 0, in_ready=0; raise out_ready[2] → transfer, EMPTY next cycle.
- Streaming: in_sel cycling 0,1,2,3 with out_ready=4'b1111 → one word per cycle, each on matching lane one cycle later, in_ready constant 1.
- Back-pressure: FULL on channel 1, out_ready=4'b1101 → word held stable 5 cycles, in_ready=0; other channels' readiness has no effect.
- Out of range: N=3, in_sel=3, in_data=8'h11 → accepted, sel_err pulse one cycle, out_valid stays 0.
- Round-robin (DMUX_RR_EN, rr_mode=1, N=3): six words → lanes 0,1,2,0,1,2; rst after third word → next word on lane 0.

Source files
------------

// File: rtl/dmux_pkg.sv
// Shared types and helpers for the dmux_stream_1byn stream demultiplexer.
// Holds the holding-register state enum, the select-width helper and lane-slice helpers.
package dmux_pkg;

  // The holding register is either empty or holds one word.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Width of a channel index for n channels. At least one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when every select code addresses a real channel.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Lowest bit of lane k in the packed output bus.
  function automatic int lane_lo(input int k, input int width);
    return k * width;
  endfunction

  // Highest bit of lane k in the packed output bus.
  function automatic int lane_hi(input int k, input int width);
    return (k * width) + width - 1;
  endfunction

endpackage : dmux_pkg

// File: rtl/dmux_rr_ptr.sv
// Modulo-N wrapping pointer with an advance enable and synchronous reset.
// Supplies the destination channel when the demultiplexer runs in round-robin mode.
module dmux_rr_ptr
  import dmux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = sel_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [SW-1:0] ptr
);

  // Step the pointer once per advance, wrapping from N-1 back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == SW'(N - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule : dmux_rr_ptr

// File: rtl/dmux_stream_1byn.sv
// Registered 1-to-N stream demultiplexer with valid/ready on every side.
// One holding register steers a word to a single output lane; the other lanes read 0.
// Optional round-robin steering is compiled in when DMUX_RR_EN is defined.
module dmux_stream_1byn
  import dmux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SW    = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SW-1:0]        in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic                 sel_err
`ifdef DMUX_RR_EN
  ,
  input  logic                 rr_mode
`endif
);

  state_e               state;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 use_rr;
  logic                 sel_bad;
  logic                 load_word;
  logic [SW-1:0]        dest_ch;
  logic [N-1:0]         load_valid;
  logic [N*WIDTH-1:0]   load_data;

  // out_valid is one-hot of the held channel, so the AND picks that consumer's ready.
  assign out_xfer = |(out_valid & out_ready);
  // Ready depends only on register state and out_ready, never on in_valid.
  assign in_ready = (state == ST_EMPTY) || out_xfer;
  assign in_xfer  = in_valid && in_ready;

`ifdef DMUX_RR_EN
  logic [SW-1:0] ptr;

  // Round-robin pointer advances only on words it actually steers.
  dmux_rr_ptr #(
    .N (N)
  ) u_rr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (in_xfer && rr_mode),
    .ptr     (ptr)
  );

  assign use_rr  = rr_mode;
  assign dest_ch = rr_mode ? ptr : in_sel;
`else
  assign use_rr  = 1'b0;
  assign dest_ch = in_sel;
`endif

  // Out-of-range selects exist only when N leaves unused codes in the select field.
  if (is_pow2(N)) begin : g_sel_full
    assign sel_bad = 1'b0;
  end else begin : g_sel_partial
    assign sel_bad = (in_sel >= SW'(N));
  end

  // A bad select is still accepted but never reaches the holding register.
  assign load_word = in_xfer && (use_rr || !sel_bad);

  // Decode the destination into a one-hot valid and a lane-placed data word.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    load_valid = '0;
    load_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (dest_ch == SW'(k)) begin
        load_valid[k]                            = 1'b1;
        load_data[lane_lo(k, WIDTH) +: WIDTH]    = in_data;
      end
    end
  end

  // Holding-register FSM with registered lane outputs and the select-error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the data lanes are reset too, because the outputs must read 0 straight after reset.
      state     <= ST_EMPTY;
      out_valid <= '0;
      out_data  <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= in_xfer && !use_rr && sel_bad;
      unique case (state)
        ST_EMPTY: begin
          if (load_word) begin
            state     <= ST_FULL;
            out_valid <= load_valid;
            out_data  <= load_data;
          end
        end
        ST_FULL: begin
          if (load_word) begin
            // in_ready implies the held word left this cycle, so replace it directly.
            out_valid <= load_valid;
            out_data  <= load_data;
          end else if (out_xfer) begin
            state     <= ST_EMPTY;
            out_valid <= '0;
            out_data  <= '0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= '0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule : dmux_stream_1byn
